// File: rtl/div_pkg.sv
// div_pkg: shared constants and types for the sequential restoring divider.
//   DIVIDEND_W / DIVISOR_W / QUOT_W : operand and result widths
//   CNT_W / LAST_STEP               : iteration counter width and final step index
//   ERR_QUOT                        : quotient reported on divide-by-zero/overflow
//   div_state_e                     : FSM state encoding
package div_pkg;
  localparam int DIVIDEND_W = 31;
  localparam int DIVISOR_W  = 14;
  localparam int QUOT_W     = DIVIDEND_W - DIVISOR_W;  // also the iteration count
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(QUOT_W - 1);
  localparam logic [QUOT_W-1:0] ERR_QUOT  = 17'h1FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_i      : partial remainder, always < divisor_i on entry
//   in_bit_i   : next dividend bit shifted into the trial value
//   divisor_i  : latched divisor
//   rem_next_o : partial remainder after the step
//   qbit_o     : quotient bit produced by the step
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 in_bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] rem_next_o,
  output logic                 qbit_o
);
  logic [DIVISOR_W:0] trial;

  always_comb begin
    trial  = {rem_i, in_bit_i};
    qbit_o = (trial >= {1'b0, divisor_i});
    // trial < 2*divisor, so the difference is below the divisor and its
    // low DIVISOR_W bits are exact even when computed modulo 2^DIVISOR_W.
    if (qbit_o) rem_next_o = trial[DIVISOR_W-1:0] - divisor_i;
    else        rem_next_o = trial[DIVISOR_W-1:0];
  end
endmodule

// File: rtl/div.sv
// div: 31-bit / 14-bit sequential restoring divider, 17-bit quotient,
// 14-bit remainder, 17 iterations per operation.
//   clk_i, reset_n_i : clock (rising edge), asynchronous active-low reset
//   div_a_i, div_b_i : dividend / divisor, sampled on an accepted start
//   div_en_i         : start request, level sampled every edge
//   div_q_o, div_r_o : registered quotient / remainder, held until next result
//   div_done_o       : one-cycle result pulse
//   div_busy_o       : high while iterating
//   div_err_o        : divide-by-zero or quotient overflow, qualified by done
//
// Handshake: a start is accepted on any edge where div_en_i=1 and the FSM is
// IDLE (including the done cycle); div_en_i in CALC is ignored. Each accepted
// start yields exactly one div_done_o pulse unless reset intervenes.
module div
  import div_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [DIVIDEND_W-1:0] div_a_i,
  input  logic [DIVISOR_W-1:0]  div_b_i,
  input  logic                  div_en_i,
  output logic [QUOT_W-1:0]     div_q_o,
  output logic [DIVISOR_W-1:0]  div_r_o,
  output logic                  div_done_o,
  output logic                  div_busy_o,
  output logic                  div_err_o
);
  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIVISOR_W-1:0] rem_q, rem_d;
  logic [DIVISOR_W-1:0] dvs_q, dvs_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB;
  // after the last step this register holds the complete quotient.
  logic [QUOT_W-1:0]    sh_q, sh_d;
  logic [QUOT_W-1:0]    quot_q, quot_d;
  logic [DIVISOR_W-1:0] rout_q, rout_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic [DIVISOR_W-1:0] step_rem;
  logic                 step_qbit;
  logic [DIVISOR_W-1:0] a_hi;

  assign a_hi = div_a_i[DIVIDEND_W-1:QUOT_W];

  div_step u_step (
    .rem_i     (rem_q),
    .in_bit_i  (sh_q[QUOT_W-1]),
    .divisor_i (dvs_q),
    .rem_next_o(step_rem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sh_d    = sh_q;
    quot_d  = quot_q;
    rout_d  = rout_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (div_en_i) begin
          // High dividend half >= divisor means the quotient needs more
          // than QUOT_W bits; b==0 is caught by the same compare.
          if (div_b_i == '0 || a_hi >= div_b_i) begin
            quot_d = ERR_QUOT;
            rout_d = '0;
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            rem_d   = a_hi;
            sh_d    = div_a_i[QUOT_W-1:0];
            dvs_d   = div_b_i;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        sh_d  = {sh_q[QUOT_W-2:0], step_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          quot_d  = {sh_q[QUOT_W-2:0], step_qbit};
          rout_d  = step_rem;
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sh_q    <= '0;
      quot_q  <= '0;
      rout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sh_q    <= sh_d;
      quot_q  <= quot_d;
      rout_q  <= rout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign div_q_o    = quot_q;
  assign div_r_o    = rout_q;
  assign div_done_o = done_q;
  assign div_busy_o = busy_q;
  assign div_err_o  = err_q;
endmodule
